// File: rtl/ddr3_cmd_sequencer.sv
// DDR3 command-path sequencer: JEDEC power-up/MRS init, closed-page single-burst
// read/write (ACT then CAS with auto-precharge), periodic auto-refresh and DQ window strobes.
module ddr3_cmd_sequencer #(
    parameter int CL       = 7,
    parameter int CWL      = 6,
    parameter int T_RCD    = 7,
    parameter int T_RP     = 7,
    parameter int T_RAS    = 20,
    parameter int T_WR     = 8,
    parameter int T_RFC    = 59,
    parameter int T_REFI   = 4160,
    parameter int T_RST    = 200,
    parameter int T_CKE    = 500,
    parameter int T_XPR    = 64,
    parameter int T_MRD    = 4,
    parameter int T_MOD    = 12,
    parameter int T_ZQINIT = 512
) (
    input  logic        ck,
    input  logic        resetbar,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [25:0] req_addr,
    output logic        init_done,
    output logic        ddr_resetbar,
    output logic        ddr_cke,
    output logic        ddr_csbar,
    output logic        ddr_rasbar,
    output logic        ddr_casbar,
    output logic        ddr_webar,
    output logic [2:0]  ddr_ba,
    output logic [13:0] ddr_a,
    output logic        wr_dq_en,
    output logic        rd_capture_en
);

    localparam int CNT_W    = 16;
    localparam int RD_HOLD  = ((T_RAS - T_RCD) > (CL + 4)) ? (T_RAS - T_RCD) : (CL + 4);
    localparam int WR_RECOV = CWL + 4 + T_WR + T_RP;
    localparam int RD_RECOV = RD_HOLD + T_RP;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_ZQ  = 4'b0110;

    // Each wait state is named after the command that was just issued on entry.
    typedef enum logic [3:0] {
        S_RST_HOLD, S_CKE_WAIT, S_XPR_WAIT, S_MR2, S_MR3, S_MR1, S_MR0,
        S_ZQ_WAIT, S_IDLE, S_RCD_WAIT, S_RECOV, S_RFC_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   refi_q, refi_d;
    logic               ref_pend_q, ref_pend_d;
    logic               clr_ref;
    logic               we_q, we_d;
    logic [12:0]        addr_q, addr_d;
    logic               init_q, init_d;
    logic               rstb_q, rstb_d;
    logic               cke_q, cke_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [2:0]         ba_q, ba_d;
    logic [13:0]        a_q, a_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;

    // Counter value seen on the edge that ends an n-cycle wait started at state entry.
    function automatic logic [CNT_W-1:0] lim(input int n);
        return CNT_W'(n - 1);
    endfunction

    function automatic logic in_burst(input logic [CNT_W-1:0] c, input int lat);
        return (c >= CNT_W'(lat - 1)) && (c <= CNT_W'(lat + 2));
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        cmd_d   = CMD_NOP;
        ba_d    = '0;
        a_d     = '0;
        rstb_d  = rstb_q;
        cke_d   = cke_q;
        init_d  = init_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        clr_ref = 1'b0;
        case (state_q)
            S_RST_HOLD: if (cnt_q == lim(T_RST)) begin
                rstb_d = 1'b1; state_d = S_CKE_WAIT; cnt_d = '0;
            end
            S_CKE_WAIT: if (cnt_q == lim(T_CKE)) begin
                cke_d = 1'b1; state_d = S_XPR_WAIT; cnt_d = '0;
            end
            S_XPR_WAIT: if (cnt_q == lim(T_XPR)) begin
                cmd_d = CMD_MRS; ba_d = 3'd2; a_d = 14'h0008; state_d = S_MR2; cnt_d = '0;
            end
            S_MR2: if (cnt_q == lim(T_MRD)) begin
                cmd_d = CMD_MRS; ba_d = 3'd3; a_d = 14'h0000; state_d = S_MR3; cnt_d = '0;
            end
            S_MR3: if (cnt_q == lim(T_MRD)) begin
                cmd_d = CMD_MRS; ba_d = 3'd1; a_d = 14'h0004; state_d = S_MR1; cnt_d = '0;
            end
            S_MR1: if (cnt_q == lim(T_MRD)) begin
                cmd_d = CMD_MRS; ba_d = 3'd0; a_d = 14'h0930; state_d = S_MR0; cnt_d = '0;
            end
            S_MR0: if (cnt_q == lim(T_MOD)) begin
                cmd_d = CMD_ZQ; a_d = 14'h0400; state_d = S_ZQ_WAIT; cnt_d = '0;
            end
            S_ZQ_WAIT: if (cnt_q == lim(T_ZQINIT)) begin
                init_d = 1'b1; state_d = S_IDLE; cnt_d = '0;
            end
            S_IDLE: begin
                cnt_d = '0;
                // Refresh wins over a waiting request; req_ready is low meanwhile.
                if (ref_pend_q) begin
                    cmd_d = CMD_REF; clr_ref = 1'b1; state_d = S_RFC_WAIT;
                end else if (req_valid && init_q) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = req_addr[12:10];
                    a_d     = {1'b0, req_addr[25:13]};
                    we_d    = req_we;
                    addr_d  = req_addr[12:0];
                    state_d = S_RCD_WAIT;
                end
            end
            S_RCD_WAIT: if (cnt_q == lim(T_RCD)) begin
                cmd_d   = we_q ? CMD_WR : CMD_RD;
                ba_d    = addr_q[12:10];
                a_d     = {3'b000, 1'b1, addr_q[9:0]};
                state_d = S_RECOV;
                cnt_d   = '0;
            end
            S_RECOV: begin
                wr_en_d = we_q && in_burst(cnt_q, CWL);
                rd_en_d = !we_q && in_burst(cnt_q, CL);
                if (cnt_q == lim(we_q ? WR_RECOV : RD_RECOV)) begin
                    state_d = S_IDLE; cnt_d = '0;
                end
            end
            S_RFC_WAIT: if (cnt_q == lim(T_RFC)) begin
                state_d = S_IDLE; cnt_d = '0;
            end
            default: begin
                state_d = S_RST_HOLD; cnt_d = '0;
            end
        endcase
    end

    // Refresh interval timer free-runs once init completes; a second expiry while
    // a refresh is still owed collapses into the one already pending.
    always_comb begin
        refi_d     = refi_q;
        ref_pend_d = ref_pend_q;
        if (clr_ref) ref_pend_d = 1'b0;
        if (init_q) begin
            if (refi_q == lim(T_REFI)) begin
                refi_d     = '0;
                ref_pend_d = 1'b1;
            end else begin
                refi_d = refi_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ck or negedge resetbar) begin
        if (!resetbar) begin
            state_q    <= S_RST_HOLD;
            cnt_q      <= '0;
            refi_q     <= '0;
            ref_pend_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            init_q     <= 1'b0;
            rstb_q     <= 1'b0;
            cke_q      <= 1'b0;
            cmd_q      <= 4'b1111;
            ba_q       <= '0;
            a_q        <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            refi_q     <= refi_d;
            ref_pend_q <= ref_pend_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            init_q     <= init_d;
            rstb_q     <= rstb_d;
            cke_q      <= cke_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            a_q        <= a_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE) && init_q && !ref_pend_q;
    assign init_done     = init_q;
    assign ddr_resetbar  = rstb_q;
    assign ddr_cke       = cke_q;
    assign ddr_csbar     = cmd_q[3];
    assign ddr_rasbar    = cmd_q[2];
    assign ddr_casbar    = cmd_q[1];
    assign ddr_webar     = cmd_q[0];
    assign ddr_ba        = ba_q;
    assign ddr_a         = a_q;
    assign wr_dq_en      = wr_en_q;
    assign rd_capture_en = rd_en_q;

endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
// Bench for ddr3_cmd_sequencer: cycle-stamped expected-command scoreboard derived from
// the documented timing rules, checked every cycle with immediate assertions.
module tb_ddr3_cmd_sequencer;

    localparam int CL = 7, CWL = 6, T_RCD = 7, T_RP = 7, T_RAS = 20, T_WR = 8;
    localparam int T_RFC = 59, T_REFI = 4160, T_RST = 200, T_CKE = 500, T_XPR = 64;
    localparam int T_MRD = 4, T_MOD = 12, T_ZQINIT = 512;
    localparam int RD_BUSY = (((T_RAS - T_RCD) > (CL + 4)) ? (T_RAS - T_RCD) : (CL + 4)) + T_RP;
    localparam int WR_BUSY = CWL + 4 + T_WR + T_RP;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] REF = 4'b0001, MRS = 4'b0000, ZQ = 4'b0110;

    logic        ck = 1'b0;
    logic        resetbar = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [25:0] req_addr = '0;
    logic        req_ready, init_done, ddr_resetbar, ddr_cke;
    logic        ddr_csbar, ddr_rasbar, ddr_casbar, ddr_webar;
    logic [2:0]  ddr_ba;
    logic [13:0] ddr_a;
    logic        wr_dq_en, rd_capture_en;

    always #5 ck = ~ck;

    ddr3_cmd_sequencer #(
        .CL(CL), .CWL(CWL), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_WR(T_WR),
        .T_RFC(T_RFC), .T_REFI(T_REFI), .T_RST(T_RST), .T_CKE(T_CKE), .T_XPR(T_XPR),
        .T_MRD(T_MRD), .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT)
    ) dut (
        .ck(ck), .resetbar(resetbar), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .init_done(init_done),
        .ddr_resetbar(ddr_resetbar), .ddr_cke(ddr_cke), .ddr_csbar(ddr_csbar),
        .ddr_rasbar(ddr_rasbar), .ddr_casbar(ddr_casbar), .ddr_webar(ddr_webar),
        .ddr_ba(ddr_ba), .ddr_a(ddr_a), .wr_dq_en(wr_dq_en), .rd_capture_en(rd_capture_en)
    );

    typedef struct {
        int         t;
        logic [3:0] cmd;
        logic [2:0] ba;
        logic [13:0] a;
    } exp_cmd_t;

    exp_cmd_t expq[$];
    int  cyc, checks, errors, acc_count;
    int  t_done, idle_at, next_exp, ref_due, wr_lo, rd_lo, tgt, n0;
    bit  pending, exp_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_resetbar"}, 32'(ddr_resetbar), 0);
        chk({tag, "_cke"}, 32'(ddr_cke), 0);
        chk({tag, "_cmd"}, 32'({ddr_csbar, ddr_rasbar, ddr_casbar, ddr_webar}), 32'hF);
        chk({tag, "_ba"}, 32'(ddr_ba), 0);
        chk({tag, "_a"}, 32'(ddr_a), 0);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_init"}, 32'(init_done), 0);
        chk({tag, "_wren"}, 32'(wr_dq_en), 0);
        chk({tag, "_rden"}, 32'(rd_capture_en), 0);
    endtask

    // Expected init schedule, counted in clock edges from reset release.
    task automatic model_reset();
        int t;
        expq.delete();
        t = T_RST + T_CKE + T_XPR;
        expq.push_back('{t, MRS, 3'd2, 14'h0008}); t += T_MRD;
        expq.push_back('{t, MRS, 3'd3, 14'h0000}); t += T_MRD;
        expq.push_back('{t, MRS, 3'd1, 14'h0004}); t += T_MRD;
        expq.push_back('{t, MRS, 3'd0, 14'h0930}); t += T_MOD;
        expq.push_back('{t, ZQ, 3'd0, 14'h0400});
        t_done    = t + T_ZQINIT;
        idle_at   = t_done;
        next_exp  = t_done + T_REFI;
        pending   = 1'b0;
        ref_due   = -1;
        wr_lo     = -100;
        rd_lo     = -100;
        exp_ready = 1'b0;
        cyc       = 0;
    endtask

    task automatic tick();
        bit          acc;
        logic        we_c;
        logic [25:0] ad_c;
        int          c_t;
        logic [3:0]  e_cmd;
        logic [2:0]  e_ba;
        logic [13:0] e_a;
        exp_cmd_t    e;
        acc  = req_valid && exp_ready;
        we_c = req_we;
        ad_c = req_addr;
        @(posedge ck);
        cyc++;
        if (acc) begin
            acc_count++;
            c_t = cyc + T_RCD;
            expq.push_back('{cyc, ACT, ad_c[12:10], {1'b0, ad_c[25:13]}});
            expq.push_back('{c_t, we_c ? WR : RD, ad_c[12:10], {4'b0001, ad_c[9:0]}});
            if (we_c) begin
                wr_lo = c_t + CWL; idle_at = c_t + WR_BUSY;
            end else begin
                rd_lo = c_t + CL;  idle_at = c_t + RD_BUSY;
            end
        end
        @(negedge ck);
        e_cmd = NOP; e_ba = '0; e_a = '0;
        if (cyc == ref_due) begin
            e_cmd = REF; pending = 1'b0; ref_due = -1; idle_at = cyc + T_RFC;
        end else if (expq.size() > 0 && expq[0].t == cyc) begin
            e = expq.pop_front();
            e_cmd = e.cmd; e_ba = e.ba; e_a = e.a;
        end
        if (cyc >= t_done && cyc == next_exp) begin
            pending = 1'b1; next_exp += T_REFI;
        end
        exp_ready = (cyc >= t_done) && (cyc >= idle_at) && !pending;
        if (cyc >= t_done && cyc >= idle_at && pending && ref_due < 0) ref_due = cyc + 1;

        chk("cmd", 32'({ddr_csbar, ddr_rasbar, ddr_casbar, ddr_webar}), 32'(e_cmd));
        if (e_cmd inside {ACT, RD, WR, MRS}) begin
            chk("ba", 32'(ddr_ba), 32'(e_ba));
            chk("a", 32'(ddr_a), 32'(e_a));
        end
        if (e_cmd == ZQ) chk("zq_a10", 32'(ddr_a[10]), 1);
        chk("ddr_resetbar", 32'(ddr_resetbar), 32'(cyc >= T_RST));
        chk("ddr_cke", 32'(ddr_cke), 32'(cyc >= T_RST + T_CKE));
        chk("init_done", 32'(init_done), 32'(cyc >= t_done));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("wr_dq_en", 32'(wr_dq_en), 32'(cyc >= wr_lo && cyc <= wr_lo + 3));
        chk("rd_capture_en", 32'(rd_capture_en), 32'(cyc >= rd_lo && cyc <= rd_lo + 3));
    endtask

    task automatic wait_ready(input int lim);
        for (int i = 0; i < lim && !exp_ready; i++) tick();
    endtask

    task automatic send(input logic we, input logic [25:0] addr);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        tick();
        req_valid = 1'b0; req_we = 1'(~we); req_addr = 26'($urandom);
    endtask

    initial begin
        checks = 0; errors = 0; acc_count = 0; cyc = 0;
        repeat (3) @(negedge ck);
        check_reset_vals("rst");
        model_reset();
        resetbar = 1'b1;
        wait_ready(3000);

        // Directed write then read from the documented scenarios.
        send(1'b1, {13'h1ABC, 3'd5, 10'h3F8});
        wait_ready(200);
        send(1'b0, 26'h0);
        wait_ready(200);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            wait_ready(200);
            send(1'($urandom), 26'($urandom));
        end
        wait_ready(200);

        // Refresh expires while a read sits in recovery, request held valid throughout.
        tgt = next_exp - 16;
        while (cyc < tgt) tick();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 26'($urandom);
        n0 = acc_count;
        for (int i = 0; i < 400 && acc_count < n0 + 2; i++) begin
            tick();
            req_we = 1'($urandom); req_addr = 26'($urandom);
        end
        req_valid = 1'b0;
        wait_ready(300);

        // Request accepted on the very edge the refresh timer expires.
        tgt = next_exp - 1;
        while (cyc < tgt) tick();
        send(1'($urandom), 26'($urandom));
        wait_ready(400);

        // Reset pulse during the ACT->CAS wait.
        send(1'($urandom), 26'($urandom));
        repeat (3) tick();
        #2 resetbar = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge ck);
        check_reset_vals("midrst_hold");
        @(negedge ck);
        model_reset();
        resetbar = 1'b1;
        wait_ready(3000);
        repeat (T_RCD + 30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_sequencer.md
# ddr3_cmd_sequencer

Command-path initiator for the x16 DDR3-1066 device (8 banks, 8K rows, 1K columns, BL8). It runs the JEDEC power-up/mode-register sequence, then accepts single-burst read/write requests from the controller front end. Each request becomes ACT → READ/WRITE with auto-precharge, using a closed-page policy. It also issues periodic auto-refresh and produces data-path enable windows for the DQ/DQS datapath block.

## Interface
Parameters (cycles of `ck`; defaults are scaled for simulation where noted):
- CL, 7, read CAS latency
- CWL, 6, CAS write latency
- T_RCD, 7, ACT to READ/WRITE
- T_RP, 7, precharge period
- T_RAS, 20, ACT to precharge minimum
- T_WR, 8, write recovery
- T_RFC, 59, REF to next command
- T_REFI, 4160, refresh interval
- T_RST, 200, ddr_resetbar low time (scaled)
- T_CKE, 500, resetbar-high to CKE-high (scaled)
- T_XPR, 64, CKE-high to first MRS
- T_MRD, 4, MRS to MRS
- T_MOD, 12, MRS to non-MRS
- T_ZQINIT, 512, ZQCL to first ACT

Ports:
- ck  in  1  controller clock; the same clock drives the memory ck
- resetbar  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_we  in  1  1=write, 0=read
- req_addr  in  26  {row[12:0], bank[2:0], col[9:0]}
- init_done  out  1  power-up sequence complete (sticky until reset)
- ddr_resetbar, ddr_cke, ddr_csbar, ddr_rasbar, ddr_casbar, ddr_webar  out  1 each  memory command pins
- ddr_ba  out  3  bank address
- ddr_a  out  14  address bus
- wr_dq_en  out  1  write-data burst window
- rd_capture_en  out  1  read-data burst window

## Operation
- All memory outputs are registered. Every cycle without a command drives NOP: csbar=0, ras/cas/we=1.
- Command encodings {csbar, rasbar, casbar, webar}:
  - ACT 0011, READ 0101, WRITE 0100, PRE 0010, REF 0001, MRS 0000
  - ZQCL 0110 with a[10]=1
- Init states: RST_HOLD → CKE_WAIT → XPR_WAIT → MR2 → MR3 → MR1 → MR0 → ZQCL → ZQ_WAIT → IDLE.
  - MRS values (ba/a): MR2 = 2/0x0008, MR3 = 3/0x0000, MR1 = 1/0x0004, MR0 = 0/0x0930 (BL8, CL7, WR8, DLL reset).
- Access states: IDLE → ACT → RCD_WAIT → CAS → RECOV → IDLE. Refresh states: IDLE → REF → RFC_WAIT → IDLE.
- Request address mapping:
  - ACT drives ba=bank, a={1'b0, row}.
  - CAS drives ba=bank, a={3'b000, 1'b1 (A10 auto-precharge), col}.
- Refresh counter:
  - Starts at init_done and counts T_REFI cycles, then sets ref_pending.
  - ref_pending clears when REF is issued.
  - Expiries while already pending are not queued.
- In IDLE, pending refresh has priority over requests.

## Timing
- Reset values: ddr_resetbar=0, ddr_cke=0, csbar=rasbar=casbar=webar=1, ba=0, a=0, req_ready=0, init_done=0, wr_dq_en=0, rd_capture_en=0.
- Asserting resetbar mid-operation forces these values asynchronously. The in-flight request is dropped and init restarts from RST_HOLD.
- Init timing:
  - ddr_resetbar rises T_RST cycles after reset release.
  - ddr_cke rises T_CKE cycles later.
  - MR2 is issued T_XPR cycles after CKE rises.
  - Consecutive MRS commands are spaced by T_MRD.
  - ZQCL follows MR0 by T_MOD.
  - init_done rises T_ZQINIT cycles after ZQCL.
- req_ready = (state==IDLE) & init_done & !ref_pending. A request is accepted at the edge where req_valid & req_ready.
- ACT appears on the pins in the cycle after acceptance (cycle A). The READ/WRITE command appears at cycle A+T_RCD.
- Write: wr_dq_en is high for cycles C+CWL … C+CWL+3 (C = write command cycle).
  - req_ready returns at C+CWL+4+T_WR+T_RP.
- Read: rd_capture_en is high for C+CL … C+CL+3.
  - req_ready returns at C+max(T_RAS−T_RCD, CL+4)+T_RP.
- If ref_pending sets on the same edge a request is accepted, the request completes first and REF follows immediately.
- REF is issued the cycle after IDLE is entered with ref_pending. req_ready stays low until T_RFC cycles after REF.
- Inputs are ignored while req_ready=0. req_addr and req_we are captured at acceptance.

## Test plan
- Reset release with default parameters → ddr_resetbar rises at cycle 200 and cke at cycle 700. MR2/MR3/MR1/MR0 appear with the exact ba/a values and spacing above, followed by ZQCL, and init_done rises 512 cycles after ZQCL.
- Write to row 0x1ABC, bank 5, col 0x3F8 → ACT with ba=5, a=0x1ABC. WRITE 7 cycles later with a=0x07F8. wr_dq_en high for 4 cycles starting 6 cycles after WRITE. req_ready returns 25 cycles after WRITE.
- Read to bank 0, row 0, col 0 → READ with a=0x0400 at ACT+7. rd_capture_en high for 4 cycles starting 7 cycles after READ. req_ready returns 20 cycles after READ.
- Refresh expiry while a read is in RECOV, with req_valid held high → REF issued before the next ACT. No ACT appears within 59 cycles of REF.
- Refresh expiry on the same edge as request acceptance → the request's ACT comes first, then REF directly after the request completes.
- resetbar pulsed low during RCD_WAIT → all outputs return to reset values immediately. No CAS command is issued, and the full init sequence repeats.
